// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller FSM state, register address type,
// per-latch control pair and the hazard rule that won in a given cycle.
package cpu_types_pkg;

    localparam int REGADDR_W_DFLT = 5;

    typedef logic [REGADDR_W_DFLT-1:0] regaddr_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } pipe_ctrl_t;

    // Which priority rule is in effect this cycle; reset and the halted
    // state are folded in so one decode drives every output.
    typedef enum logic [3:0] {
        R_RESET  = 4'd0,
        R_HALTED = 4'd1,
        R_HALT   = 4'd2,
        R_DWAIT  = 4'd3,
        R_REDIR  = 4'd4,
        R_LU     = 4'd5,
        R_IMISS  = 4'd6,
        R_SQUASH = 4'd7,
        R_RUN    = 4'd8
    } ctrl_rule_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the EX-stage load writes a register the
// ID-stage instruction reads. Register 0 never creates a dependency.
module hazard_detect #(
    parameter int REGADDR_W = 5
) (
    input  logic                 ex_memread,
    input  logic [REGADDR_W-1:0] ex_rt,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    output logic                 lu
);

    // Pure combinational compare, shared with the forwarding unit
    always_comb begin
        lu = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Controls are combinational from registered state plus current inputs.
// Optional performance counters: define PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ihit,
    input  logic                 dhit,
    input  logic                 mem_dmemren,
    input  logic                 mem_dmemwen,
    input  logic [REGADDR_W-1:0] id_rs,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 ex_memread,
    input  logic [REGADDR_W-1:0] ex_rt,
    input  logic                 ex_redirect,
    input  logic                 wb_halt,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_flush,
    output logic                 exmem_en,
    output logic                 exmem_flush,
    output logic                 memwb_en,
    output logic                 memwb_flush,
    output logic                 halted,
    output logic [CNT_W-1:0]     cnt_lu,
    output logic [CNT_W-1:0]     cnt_dwait,
    output logic [CNT_W-1:0]     cnt_istall,
    output logic [CNT_W-1:0]     cnt_redirect
);

    ctrl_state_t state;
    logic        squash_pend;
    logic        lu;
    logic        dreq;
    ctrl_rule_t  rule;
    logic        pc_go;
    pipe_ctrl_t  ifid, idex, exmem, memwb;

    hazard_detect #(.REGADDR_W(REGADDR_W)) u_hazard (
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .lu         (lu)
    );

    assign dreq = mem_dmemren | mem_dmemwen;

    // Fixed-priority rule select; DWAIT falls through to the RUN rules once dhit arrives
    always_comb begin
        rule = R_RUN;
        if (RST)                     rule = R_RESET;
        else if (state == HALTED)    rule = R_HALTED;
        else if (wb_halt)            rule = R_HALT;
        else if (dreq && !dhit)      rule = R_DWAIT;
        else if (ex_redirect)        rule = R_REDIR;
        else if (lu)                 rule = R_LU;
        else if (!ihit)              rule = R_IMISS;
        else if (squash_pend)        rule = R_SQUASH;
        else                         rule = R_RUN;
    end

    // Decode the winning rule into per-latch enable/flush pairs
    always_comb begin
        pc_go = 1'b0;
        ifid  = '{en: 1'b0, flush: 1'b0};
        idex  = '{en: 1'b0, flush: 1'b0};
        exmem = '{en: 1'b0, flush: 1'b0};
        memwb = '{en: 1'b0, flush: 1'b0};
        unique case (rule)
            R_RESET: begin
                ifid.flush  = 1'b1;
                idex.flush  = 1'b1;
                exmem.flush = 1'b1;
                memwb.flush = 1'b1;
            end
            R_HALTED, R_HALT: ;
            R_DWAIT: begin
                // Bubble into WB so the frozen MEM instruction is not written back twice
                memwb.flush = 1'b1;
            end
            R_REDIR: begin
                pc_go       = 1'b1;
                ifid.flush  = 1'b1;
                idex.flush  = 1'b1;
                exmem.en    = 1'b1;
                memwb.en    = 1'b1;
            end
            R_LU: begin
                idex.flush  = 1'b1;
                exmem.en    = 1'b1;
                memwb.en    = 1'b1;
            end
            R_IMISS, R_SQUASH: begin
                ifid.flush  = 1'b1;
                idex.en     = 1'b1;
                exmem.en    = 1'b1;
                memwb.en    = 1'b1;
            end
            default: begin
                pc_go       = 1'b1;
                ifid.en     = 1'b1;
                idex.en     = 1'b1;
                exmem.en    = 1'b1;
                memwb.en    = 1'b1;
            end
        endcase
    end

    // Flush dominates enable at every latch
    assign pc_en       = pc_go;
    assign ifid_en     = ifid.en  & ~ifid.flush;
    assign ifid_flush  = ifid.flush;
    assign idex_en     = idex.en  & ~idex.flush;
    assign idex_flush  = idex.flush;
    assign exmem_en    = exmem.en & ~exmem.flush;
    assign exmem_flush = exmem.flush;
    assign memwb_en    = memwb.en & ~memwb.flush;
    assign memwb_flush = memwb.flush;
    assign halted      = (state == HALTED) && !RST;

    // Controller FSM and wrong-path fetch tracking
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            squash_pend <= 1'b0;
        end else begin
            unique case (rule)
                R_HALT:   state <= HALTED;
                R_DWAIT:  state <= DWAIT;
                R_REDIR: begin
                    state <= RUN;
                    // Only one fetch is ever outstanding, so a pending squash stays pending
                    squash_pend <= squash_pend | ~ihit;
                end
                R_SQUASH: begin
                    state       <= RUN;
                    squash_pend <= 1'b0;
                end
                R_LU, R_IMISS, R_RUN: state <= RUN;
                default: ;
            endcase
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] c_lu, c_dwait, c_istall, c_redirect;

    // Saturating event counters, one increment per cycle the rule fires
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_lu       <= '0;
            c_dwait    <= '0;
            c_istall   <= '0;
            c_redirect <= '0;
        end else begin
            if (rule == R_LU && !(&c_lu))
                c_lu <= c_lu + CNT_W'(1);
            if (rule == R_DWAIT && !(&c_dwait))
                c_dwait <= c_dwait + CNT_W'(1);
            if ((rule == R_IMISS || rule == R_SQUASH) && !(&c_istall))
                c_istall <= c_istall + CNT_W'(1);
            if (rule == R_REDIR && !(&c_redirect))
                c_redirect <= c_redirect + CNT_W'(1);
        end
    end

    assign cnt_lu       = c_lu;
    assign cnt_dwait    = c_dwait;
    assign cnt_istall   = c_istall;
    assign cnt_redirect = c_redirect;
`else
    assign cnt_lu       = '0;
    assign cnt_dwait    = '0;
    assign cnt_istall   = '0;
    assign cnt_redirect = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a reference model pushes the expected
// controls per cycle, and they are popped and compared mid-cycle.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST = 1'b1, ihit = 1'b0, dhit = 1'b0, mem_dmemren = 1'b0, mem_dmemwen = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       ex_memread = 1'b0, ex_redirect = 1'b0, wb_halt = 1'b0;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic       exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
    logic [31:0] cnt_lu, cnt_dwait, cnt_istall, cnt_redirect;

    pipeline_ctrl #(.REGADDR_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dmemren(mem_dmemren), .mem_dmemwen(mem_dmemwen),
        .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .memwb_en(memwb_en), .memwb_flush(memwb_flush),
        .halted(halted), .cnt_lu(cnt_lu), .cnt_dwait(cnt_dwait),
        .cnt_istall(cnt_istall), .cnt_redirect(cnt_redirect)
    );

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
    localparam logic [8:0] C_RST   = 9'b0_01_01_01_01;
    localparam logic [8:0] C_FRZ   = 9'b0_00_00_00_00;
    localparam logic [8:0] C_DWAIT = 9'b0_00_00_00_01;
    localparam logic [8:0] C_REDIR = 9'b1_01_01_10_10;
    localparam logic [8:0] C_LU    = 9'b0_00_01_10_10;
    localparam logic [8:0] C_ISTL  = 9'b0_01_10_10_10;
    localparam logic [8:0] C_RUN   = 9'b1_10_10_10_10;

    typedef struct packed {
        logic [8:0]       ctrl;
        logic             hlt;
        logic [3:0][31:0] cnt;   // 0 lu, 1 dwait, 2 istall, 3 redirect
    } exp_t;

    exp_t sbq[$];
    int   errs = 0, checks = 0;

    // reference model state: 0 RUN, 1 DWAIT, 2 HALTED
    int          m_st = 0;
    bit          m_sq = 0;
    logic [31:0] m_cnt [4] = '{0, 0, 0, 0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic bump(input int i);
        if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic cyc(input logic rst, input logic ih, input logic dh, input logic ren,
                       input logic wen, input logic exmr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic redir, input logic halt);
        exp_t e, g;
        bit   luh;
        @(negedge CLK);
        RST = rst; ihit = ih; dhit = dh; mem_dmemren = ren; mem_dmemwen = wen;
        ex_memread = exmr; ex_rt = ert; id_rs = rs; id_rt = rt;
        ex_redirect = redir; wb_halt = halt;

        luh = exmr && ert != 0 && (ert == rs || ert == rt);
        e.hlt = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
        for (int i = 0; i < 4; i++) e.cnt[i] = m_cnt[i];
`else
        e.cnt = '0;
`endif
        if (rst) begin
            e.ctrl = C_RST;
        end else if (m_st == 2) begin
            e.ctrl = C_FRZ; e.hlt = 1'b1;
        end else if (halt) begin
            e.ctrl = C_FRZ;
        end else if ((ren || wen) && !dh) begin
            e.ctrl = C_DWAIT;
        end else if (redir) begin
            e.ctrl = C_REDIR;
        end else if (luh) begin
            e.ctrl = C_LU;
        end else if (!ih || m_sq) begin
            e.ctrl = C_ISTL;
        end else begin
            e.ctrl = C_RUN;
        end
        sbq.push_back(e);

        #2;
        g = sbq.pop_front();
        chk("ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, exmem_flush, memwb_en, memwb_flush}, g.ctrl);
        chk("halted", halted, g.hlt);
        chk("cnt_lu", cnt_lu, g.cnt[0]);
        chk("cnt_dwait", cnt_dwait, g.cnt[1]);
        chk("cnt_istall", cnt_istall, g.cnt[2]);
        chk("cnt_redirect", cnt_redirect, g.cnt[3]);

        // advance model to the post-edge state
        if (rst) begin
            m_st = 0; m_sq = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (m_st == 2) begin
        end else if (halt) begin
            m_st = 2;
        end else if ((ren || wen) && !dh) begin
            m_st = 1; bump(1);
        end else if (redir) begin
            m_st = 0; bump(3);
            if (!ih) m_sq = 1;
        end else if (luh) begin
            m_st = 0; bump(0);
        end else if (!ih) begin
            m_st = 0; bump(2);
        end else if (m_sq) begin
            m_st = 0; m_sq = 0; bump(2);
        end else begin
            m_st = 0;
        end
    endtask

    // shorthand for a quiet cycle with only fetch/data hits chosen
    task automatic idle(input logic ih, input logic dh);
        cyc(0, ih, dh, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        // reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);

        // load-use, then the same with r0 as destination
        cyc(0, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0);
        idle(1, 0);
        cyc(0, 1, 0, 0, 0, 1, 5'd8, 5'd2, 5'd8, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1, 0);

        // data wait: three miss cycles, then the hit
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);

        // redirect during an I-miss: squash, two misses, discard, then normal
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0);
        idle(0, 0);
        idle(1, 0);
        idle(1, 0);

        // redirect under a store wait: freeze first, flush once data completes
        cyc(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        idle(1, 0);

        // halt alongside a load-use, sticky through toggling hits
        cyc(0, 1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1);
        for (int i = 0; i < 10; i++)
            cyc(0, i[0], ~i[0], i[1], 0, 1, 5'd8, 5'd8, 5'd0, i[2], 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);

        // reset mid-DWAIT while a squash is pending
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        idle(1, 0);

        // random mix with small register numbers so hazards collide often
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0,
                $urandom_range(0, 79) == 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
